cmd_issuer: RTL and testbench

Sequencer between the command FIFO (`cmd_queue`) and the SIMD core array. It pops one command at a time from the queue and dispatches it over a valid/ready handshake to an idle core chosen round-robin. It tracks per-core busy state until each core signals completion. It reports overall activity to the host-side control so the CPU can tell when all work has drained.

---
 rtl/cmd_issuer.sv | 124 ++++++++++++
 tb/tb_cmd_issuer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_issuer.sv
// cmd_issuer: pops one command at a time from cmd_queue and dispatches it over a
// valid/ready handshake to an idle SIMD core chosen round-robin. Tracks per-core
// busy state until each core pulses done, and reports overall activity.
// Optional build macro: CMD_ISSUER_PERF_EN adds o_issued_cnt / o_stall_cnt counters.
module cmd_issuer #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned CMD_WIDTH = 248
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_q_read,
    input  logic                 i_q_empty,
    input  logic [CMD_WIDTH-1:0] i_q_data,
    output logic [NUM_CORES-1:0] o_core_valid,
    input  logic [NUM_CORES-1:0] i_core_ready,
    output logic [CMD_WIDTH-1:0] o_core_cmd,
    input  logic [NUM_CORES-1:0] i_core_done,
    output logic [NUM_CORES-1:0] o_core_busy,
    output logic                 o_busy
`ifdef CMD_ISSUER_PERF_EN
    ,
    output logic [31:0]          o_issued_cnt,
    output logic [31:0]          o_stall_cnt
`endif
);

    localparam int unsigned PtrW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {StIdle, StFetch, StArb, StIssue} state_e;

    state_e               state;
    logic [PtrW-1:0]      rr_ptr;
    logic [PtrW-1:0]      sel;
    logic [PtrW-1:0]      pick;
    logic                 pick_found;
    logic [PtrW:0]        cand;
    logic [NUM_CORES-1:0] sel_onehot;
    logic                 accept;

    // Round-robin search: first free core at or after rr_ptr, wrapping modulo NUM_CORES.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            cand = {1'b0, rr_ptr} + (PtrW + 1)'(k);
            if (cand >= (PtrW + 1)'(NUM_CORES)) begin
                cand = cand - (PtrW + 1)'(NUM_CORES);
            end
            if (!pick_found && !o_core_busy[cand[PtrW-1:0]]) begin
                pick_found = 1'b1;
                pick       = cand[PtrW-1:0];
            end
        end
    end

    // Handshake decode; valid is a pure state decode, the pop strobe is additionally
    // gated by empty so the queue is never read while it has nothing to give.
    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
        accept          = (state == StIssue) && i_core_ready[sel];
        o_core_valid    = (state == StIssue) ? sel_onehot : '0;
        o_q_read        = (state == StIdle) && !i_q_empty;
    end

    // Dispatch FSM with command register, busy tracking and activity flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= StIdle;
            sel         <= '0;
            rr_ptr      <= '0;
            o_core_cmd  <= '0;
            o_core_busy <= '0;
            o_busy      <= 1'b0;
        end else begin
            o_busy      <= (state != StIdle) || (|o_core_busy);
            // A busy core is never selected, so done and the set never collide.
            o_core_busy <= (o_core_busy & ~i_core_done) | (accept ? sel_onehot : '0);
            unique case (state)
                StIdle: begin
                    if (!i_q_empty) begin
                        state <= StFetch;
                    end
                end
                StFetch: begin
                    o_core_cmd <= i_q_data;
                    state      <= StArb;
                end
                StArb: begin
                    if (pick_found) begin
                        sel   <= pick;
                        state <= StIssue;
                    end
                end
                StIssue: begin
                    if (accept) begin
                        rr_ptr <= (sel == PtrW'(NUM_CORES - 1)) ? '0 : sel + PtrW'(1);
                        state  <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef CMD_ISSUER_PERF_EN
    // Counters: accepted handshakes, and cycles lost to no free core or ready low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_issued_cnt <= '0;
            o_stall_cnt  <= '0;
        end else begin
            if (accept) begin
                o_issued_cnt <= o_issued_cnt + 32'd1;
            end
            if (((state == StArb) && !pick_found) || ((state == StIssue) && !accept)) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmd_issuer.sv
// tb_cmd_issuer: directed scenarios plus a randomized run checked against a
// transaction-level reference (FIFO queue, busy set, round-robin pointer).
module tb_cmd_issuer;

    localparam int NC = 4;
    localparam int CW = 248;

    logic          clk = 1'b0;
    logic          rst;
    logic          q_read;
    logic          q_empty;
    logic [CW-1:0] q_data;
    logic [NC-1:0] core_valid;
    logic [NC-1:0] core_ready;
    logic [CW-1:0] core_cmd;
    logic [NC-1:0] core_done;
    logic [NC-1:0] core_busy;
    logic          obusy;
`ifdef CMD_ISSUER_PERF_EN
    logic [31:0]   issued_cnt;
    logic [31:0]   stall_cnt;
`endif

    cmd_issuer #(
        .NUM_CORES (NC),
        .CMD_WIDTH (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_q_read     (q_read),
        .i_q_empty    (q_empty),
        .i_q_data     (q_data),
        .o_core_valid (core_valid),
        .i_core_ready (core_ready),
        .o_core_cmd   (core_cmd),
        .i_core_done  (core_done),
        .o_core_busy  (core_busy),
        .o_busy       (obusy)
`ifdef CMD_ISSUER_PERF_EN
        ,
        .o_issued_cnt (issued_cnt),
        .o_stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state.
    logic [CW-1:0] fifo[$];
    logic [CW-1:0] m_cmd = '0;
    logic [NC-1:0] m_busy = '0;
    logic [NC-1:0] m_busy_prev = '0;
    int            m_rr = 0;
    logic          m_inflight = 1'b0;
    int            m_age = 0;
    logic          m_seen_valid = 1'b0;
    logic          m_obusy = 1'b0;
    logic [NC-1:0] m_prev_valid = '0;
    int            m_issued = 0;
    int            m_stall = 0;

    function automatic logic [CW-1:0] rand_cmd();
        logic [CW-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = (v << 32) | CW'($urandom);
        return v;
    endfunction

    // Round-robin rule: first free core at or after rr, -1 if none.
    function automatic int exp_core(logic [NC-1:0] b, int rr);
        for (int i = 0; i < NC; i++) begin
            if (!b[(rr + i) % NC]) return (rr + i) % NC;
        end
        return -1;
    endfunction

    task automatic push_cmd(input logic [CW-1:0] c);
        fifo.push_back(c);
        q_empty = 1'b0;
    endtask

    // Advance one clock; sample inputs/outputs before the edge, update the model after it.
    task automatic tick();
        logic          rd, rs, hs, obn;
        logic [NC-1:0] v, r, d, nb;
        #2;
        rd = q_read; rs = rst; v = core_valid; r = core_ready; d = core_done;
        @(posedge clk);
        #1;
        cyc++;
        if (m_inflight && m_age >= 2 && v == '0 && (&m_busy)) m_stall++;
        if (v != '0 && (v & r) == '0) m_stall++;
        obn = m_inflight || (|m_busy);
        nb  = m_busy & ~d;
        hs  = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (v[k] && r[k]) begin
                nb[k] = 1'b1;
                m_rr  = (k + 1) % NC;
                hs    = 1'b1;
            end
        end
        if (v != '0) m_seen_valid = 1'b1;
        if (hs) begin
            m_inflight = 1'b0;
            m_issued++;
        end
        if (rd) begin
            if (fifo.size() > 0) begin
                m_cmd  = fifo.pop_front();
                q_data = m_cmd;
            end
            q_empty      = (fifo.size() == 0);
            m_inflight   = 1'b1;
            m_age        = 0;
            m_seen_valid = 1'b0;
        end
        if (m_inflight) m_age++;
        m_busy_prev  = m_busy;
        m_busy       = nb;
        m_obusy      = obn;
        m_prev_valid = v;
        if (rs) begin
            m_busy = '0; m_busy_prev = '0; m_rr = 0; m_inflight = 1'b0; m_obusy = 1'b0;
            m_seen_valid = 1'b0; m_age = 0; m_issued = 0; m_stall = 0; m_prev_valid = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; core_ready = '1; core_done = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (q_read !== 1'b0) begin errors++;
            $display("FAIL reset_q_read: got %b expected 0", q_read); end
        checks++; if (core_valid !== '0) begin errors++;
            $display("FAIL reset_valid: got %b expected 0", core_valid); end
        checks++; if (core_cmd !== '0) begin errors++;
            $display("FAIL reset_cmd: got %h expected 0", core_cmd); end
        checks++; if (core_busy !== '0) begin errors++;
            $display("FAIL reset_core_busy: got %b expected 0", core_busy); end
        checks++; if (obusy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b expected 0", obusy); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({q_read, core_valid, core_busy, obusy} !== '0 || core_cmd !== '0) bad++;
        end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL idle_empty: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_fill_cores();
        logic [CW-1:0] cmds[7];
        int t0, p, n, bad;
        core_ready = '1; core_done = '0;
        for (int i = 0; i < 7; i++) cmds[i] = rand_cmd();
        for (int i = 0; i < 5; i++) push_cmd(cmds[i]);
        #1;
        checks++; if (q_read !== 1'b1) begin errors++;
            $display("FAIL first_pop: got %b expected 1", q_read); end
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (core_valid == '0 && n < 20) begin tick(); n++; end
            if (i == 0) begin
                checks++; if (cyc - t0 != 3) begin errors++;
                    $display("FAIL first_latency: got %0d expected 3", cyc - t0); end
            end
            checks++; if (core_valid !== NC'(1) << i) begin errors++;
                $display("FAIL fill_core%0d: got %b expected %b", i, core_valid, NC'(1) << i); end
            checks++; if (core_cmd !== cmds[i]) begin errors++;
                $display("FAIL fill_cmd%0d: got %h expected %h", i, core_cmd, cmds[i]); end
            tick();
        end
        checks++; if (core_busy !== 4'b1111) begin errors++;
            $display("FAIL all_busy: got %b expected 1111", core_busy); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (core_valid !== '0 || q_read !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL fifth_waits: got %0d bad cycles expected 0", bad); end
        core_done = 4'b0100; p = cyc;
        tick();
        core_done = '0;
        n = 0;
        while (core_valid == '0 && n < 10) begin tick(); n++; end
        checks++; if (core_valid !== 4'b0100) begin errors++;
            $display("FAIL freed_core2: got %b expected 0100", core_valid); end
        checks++; if (cyc - p != 2) begin errors++;
            $display("FAIL freed_latency: got %0d expected 2", cyc - p); end
        checks++; if (core_cmd !== cmds[4]) begin errors++;
            $display("FAIL freed_cmd: got %h expected %h", core_cmd, cmds[4]); end
        tick();
        // rr_ptr now 3; free cores 0 and 3 only.
        push_cmd(cmds[5]); push_cmd(cmds[6]);
        core_done = 4'b1001;
        tick();
        core_done = '0;
        n = 0;
        while (core_valid == '0 && n < 10) begin tick(); n++; end
        checks++; if (core_valid !== 4'b1000 || core_cmd !== cmds[5]) begin errors++;
            $display("FAIL rr_wrap3: got %b expected 1000", core_valid); end
        tick();
        n = 0;
        while (core_valid == '0 && n < 10) begin tick(); n++; end
        checks++; if (core_valid !== 4'b0001 || core_cmd !== cmds[6]) begin errors++;
            $display("FAIL rr_wrap0: got %b expected 0001", core_valid); end
        tick();
        checks++; if (core_busy !== 4'b1111) begin errors++;
            $display("FAIL rr_busy: got %b expected 1111", core_busy); end
    endtask

    task automatic test_ready_stall();
        logic [CW-1:0] c;
        logic [NC-1:0] v0;
        int n, bad;
`ifdef CMD_ISSUER_PERF_EN
        logic [31:0] s0;
`endif
        rst = 1'b1; tick(); rst = 1'b0;
        core_ready = '0; core_done = '0;
        c = rand_cmd();
        push_cmd(c);
        n = 0;
        while (core_valid == '0 && n < 20) begin tick(); n++; end
        v0 = core_valid;
`ifdef CMD_ISSUER_PERF_EN
        s0 = stall_cnt;
`endif
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (core_valid !== 4'b0001 || core_cmd !== c) bad++;
            tick();
        end
        checks++; if (bad != 0 || v0 !== 4'b0001) begin errors++;
            $display("FAIL stall_hold: got %0d unstable cycles, first valid %b expected 0001", bad, v0); end
        checks++; if (core_valid !== 4'b0001) begin errors++;
            $display("FAIL stall_still_valid: got %b expected 0001", core_valid); end
`ifdef CMD_ISSUER_PERF_EN
        checks++; if (stall_cnt - s0 !== 32'd10) begin errors++;
            $display("FAIL stall_cnt: got %0d expected 10", stall_cnt - s0); end
`endif
        core_ready = '1;
        tick();
        checks++; if (core_valid !== '0 || core_busy !== 4'b0001) begin errors++;
            $display("FAIL stall_accept: got valid %b busy %b expected 0000 0001", core_valid, core_busy); end
    endtask

    task automatic test_reset_in_issue();
        logic [CW-1:0] a, b;
        int n, bad;
        rst = 1'b1; tick(); rst = 1'b0;
        core_done = '0; core_ready = '1;
        push_cmd(rand_cmd());
        n = 0;
        while (core_valid == '0 && n < 20) begin tick(); n++; end
        tick();
        core_ready = '0;
        a = rand_cmd();
        push_cmd(a);
        n = 0;
        while (core_valid == '0 && n < 20) begin tick(); n++; end
        checks++; if (core_valid !== 4'b0010 || core_busy !== 4'b0001) begin errors++;
            $display("FAIL pre_reset: got valid %b busy %b expected 0010 0001", core_valid, core_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        core_ready = '1;
        checks++; if (core_valid !== '0 || core_busy !== '0 || q_read !== 1'b0) begin errors++;
            $display("FAIL mid_reset: got valid %b busy %b read %b expected all 0",
                     core_valid, core_busy, q_read); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (core_valid !== '0) bad++;
        end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL dropped_redelivered: got %0d valid cycles expected 0", bad); end
        b = rand_cmd();
        push_cmd(b);
        n = 0;
        while (core_valid == '0 && n < 20) begin tick(); n++; end
        checks++; if (core_valid !== 4'b0001 || core_cmd !== b) begin errors++;
            $display("FAIL post_reset_issue: got %b %h expected 0001 %h", core_valid, core_cmd, b); end
        tick();
    endtask

    task automatic test_random();
        logic [NC-1:0] exp_v;
        int ec, pushed, n;
        rst = 1'b1; core_done = '0; core_ready = '0; tick(); rst = 1'b0;
        pushed = 0;
        for (int c = 0; c < 900; c++) begin
            checks++; if (core_busy !== m_busy) begin errors++;
                $display("FAIL rnd_core_busy@%0d: got %b expected %b", cyc, core_busy, m_busy); end
            checks++; if (obusy !== m_obusy) begin errors++;
                $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, obusy, m_obusy); end
            checks++; if (q_read !== (!m_inflight && !q_empty)) begin errors++;
                $display("FAIL rnd_q_read@%0d: got %b expected %b", cyc, q_read,
                         !m_inflight && !q_empty); end
            if (!m_inflight || m_age < 3) exp_v = '0;
            else if (m_seen_valid) exp_v = m_prev_valid;
            else begin
                ec = exp_core(m_busy_prev, m_rr);
                exp_v = (ec < 0) ? '0 : NC'(1) << ec;
            end
            checks++; if (core_valid !== exp_v) begin errors++;
                $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, core_valid, exp_v); end
            if (exp_v != '0) begin
                checks++; if (core_cmd !== m_cmd) begin errors++;
                    $display("FAIL rnd_cmd@%0d: got %h expected %h", cyc, core_cmd, m_cmd); end
            end
`ifdef CMD_ISSUER_PERF_EN
            checks++; if (issued_cnt !== 32'(m_issued) || stall_cnt !== 32'(m_stall)) begin
                errors++;
                $display("FAIL rnd_perf@%0d: got %0d/%0d expected %0d/%0d", cyc, issued_cnt,
                         stall_cnt, m_issued, m_stall); end
`endif
            if (c < 600 && $urandom_range(0, 7) == 0) begin
                push_cmd(rand_cmd());
                pushed++;
            end
            core_ready = (c < 600) ? NC'($urandom) : '1;
            for (int k = 0; k < NC; k++) begin
                if (m_busy[k]) core_done[k] = ($urandom_range(0, 3) == 0);
                else core_done[k] = !core_valid[k] && ($urandom_range(0, 15) == 0);
            end
            tick();
        end
        core_done = '0;
        n = 0;
        while ((fifo.size() != 0 || m_inflight) && n < 200) begin
            for (int k = 0; k < NC; k++) core_done[k] = m_busy[k];
            tick(); n++;
        end
        checks++; if (m_issued != pushed || fifo.size() != 0) begin errors++;
            $display("FAIL rnd_drain: got %0d issued expected %0d", m_issued, pushed); end
    endtask

    initial begin
        rst = 1'b1; q_empty = 1'b1; q_data = '0; core_ready = '0; core_done = '0;
        @(negedge clk);
        test_reset();
        test_fill_cores();
        test_ready_stall();
        test_reset_in_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
